// File: rtl/encoder_ctrl_pkg.sv
// Shared types and constants for the rotary-encoder menu controller.
package encoder_ctrl_pkg;

   typedef enum logic {NAV = 1'b0, EDIT = 1'b1} mode_e;

   typedef enum logic [1:0] {NONE = 2'd0, CW = 2'd1, CCW = 2'd2} detent_e;

   // Quadrature states encoded as {B,A}
   localparam logic [1:0] Q00 = 2'b00;
   localparam logic [1:0] Q01 = 2'b01;
   localparam logic [1:0] Q11 = 2'b11;
   localparam logic [1:0] Q10 = 2'b10;

   function automatic logic is_cw_step(input logic [1:0] from, input logic [1:0] to);
      logic [3:0] pair;
      pair = {from, to};
      case (pair)
         {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: is_cw_step = 1'b1;
         default:                                        is_cw_step = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/quad_detent_decoder.sv
// Synchronises quadrature A/B, accumulates quarter-steps and emits a registered detent code.
module quad_detent_decoder
   import encoder_ctrl_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    enc_a,
   input  logic    enc_b,
   output detent_e detent
);

   logic [1:0]        a_sync, b_sync;
   logic [1:0]        cur;
   logic [1:0]        prev_q;
   logic signed [3:0] acc_q, acc_d;
   detent_e           det_q, det_d;

   assign cur    = {b_sync[1], a_sync[1]};
   assign detent = det_q;

   always_comb begin
      acc_d = acc_q;
      det_d = NONE;
      if (cur != prev_q) begin
         if ((cur ^ prev_q) == 2'b11) begin
            acc_d = 4'sd0;
         end else begin
            if (is_cw_step(prev_q, cur)) begin
               acc_d = (acc_q == 4'sd4) ? 4'sd4 : acc_q + 4'sd1;
            end else begin
               acc_d = (acc_q == -4'sd4) ? -4'sd4 : acc_q - 4'sd1;
            end
            // Detent is judged on the accumulator including the final quarter-step
            if (cur == Q00) begin
               if (acc_d == 4'sd4) begin
                  det_d = CW;
               end else if (acc_d == -4'sd4) begin
                  det_d = CCW;
               end
               acc_d = 4'sd0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sync <= 2'b00;
         b_sync <= 2'b00;
         prev_q <= Q00;
         acc_q  <= 4'sd0;
         det_q  <= NONE;
      end else begin
         a_sync <= {a_sync[0], enc_a};
         b_sync <= {b_sync[0], enc_b};
         prev_q <= cur;
         acc_q  <= acc_d;
         det_q  <= det_d;
      end
   end

endmodule

// File: rtl/encoder_menu_ctrl.sv
// Encoder/pushbutton menu: button debounce, hold timing, NAV/EDIT mode FSM and parameter bank.
module encoder_menu_ctrl
   import encoder_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PARAMS     = 4,
   parameter int unsigned VAL_W          = 8,
   parameter int unsigned DEBOUNCE_CYC   = 4,
   parameter int unsigned LONG_PRESS_CYC = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enc_a,
   input  logic                          enc_b,
   input  logic                          btn_n,
   output logic [$clog2(NUM_PARAMS)-1:0] sel_idx,
   output logic                          edit_mode,
   output logic [VAL_W-1:0]              sel_val,
   output logic [NUM_PARAMS*VAL_W-1:0]   params,
   output logic                          update_pulse,
   output logic                          long_press
);

   localparam int unsigned IDX_W  = $clog2(NUM_PARAMS);
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYC + 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYC);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYC - 1);
   localparam logic [VAL_W-1:0]  VAL_MAX   = '1;

   detent_e           detent;
   logic [1:0]        btn_sync;
   logic              db_q, db_prev_q;
   logic [DB_W-1:0]   db_cnt_q;
   logic [HOLD_W-1:0] hold_q;
   logic              short_evt, long_evt;

   mode_e            mode_q, mode_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic [VAL_W-1:0] params_q [NUM_PARAMS];
   logic [VAL_W-1:0] params_d [NUM_PARAMS];
   logic [VAL_W-1:0] cur_val;
   logic             update_q, update_d;
   logic             long_q;

   quad_detent_decoder u_quad (
      .clk    (clk),
      .rst_n  (rst_n),
      .enc_a  (enc_a),
      .enc_b  (enc_b),
      .detent (detent)
   );

   // Button: db_q is the debounced level (1 = released)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_sync  <= 2'b11;
         db_q      <= 1'b1;
         db_prev_q <= 1'b1;
         db_cnt_q  <= '0;
         hold_q    <= '0;
      end else begin
         btn_sync  <= {btn_sync[0], btn_n};
         db_prev_q <= db_q;
         if (btn_sync[1] != db_q) begin
            if (db_cnt_q == DB_LAST) begin
               db_q     <= btn_sync[1];
               db_cnt_q <= '0;
            end else begin
               db_cnt_q <= db_cnt_q + 1'b1;
            end
         end else begin
            db_cnt_q <= '0;
         end
         if (!db_q) begin
            if (hold_q != HOLD_MAX) hold_q <= hold_q + 1'b1;
         end else begin
            hold_q <= '0;
         end
      end
   end

   // Release is seen one cycle after db_q rises, while hold_q still holds the press length
   assign short_evt = !db_prev_q && db_q && (hold_q < HOLD_MAX);
   assign long_evt  = !db_q && (hold_q == HOLD_LAST);

   assign cur_val = params_q[sel_q];

   always_comb begin
      mode_d   = mode_q;
      sel_d    = sel_q;
      params_d = params_q;
      update_d = 1'b0;
      if (short_evt) begin
         mode_d = (mode_q == NAV) ? EDIT : NAV;
      end else if (long_evt) begin
         if (mode_q == EDIT) begin
            params_d[sel_q] = '0;
            update_d        = 1'b1;
            mode_d          = NAV;
         end
      end else if (detent != NONE) begin
         if (mode_q == NAV) begin
            sel_d = (detent == CW) ? sel_q + 1'b1 : sel_q - 1'b1;
         end else if (detent == CW && cur_val != VAL_MAX) begin
            params_d[sel_q] = cur_val + 1'b1;
            update_d        = 1'b1;
         end else if (detent == CCW && cur_val != '0) begin
            params_d[sel_q] = cur_val - 1'b1;
            update_d        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= NAV;
         sel_q    <= '0;
         update_q <= 1'b0;
         long_q   <= 1'b0;
         for (int i = 0; i < NUM_PARAMS; i++) params_q[i] <= '0;
      end else begin
         mode_q   <= mode_d;
         sel_q    <= sel_d;
         update_q <= update_d;
         long_q   <= long_evt;
         for (int i = 0; i < NUM_PARAMS; i++) params_q[i] <= params_d[i];
      end
   end

   for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_flat
      assign params[g*VAL_W +: VAL_W] = params_q[g];
   end

   assign sel_idx      = sel_q;
   assign edit_mode    = (mode_q == EDIT);
   assign sel_val      = cur_val;
   assign update_pulse = update_q;
   assign long_press   = long_q;

endmodule

// File: tb/tb_encoder_menu_ctrl.sv
// Directed self-checking bench for encoder_menu_ctrl.
module tb_encoder_menu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enc_a = 1'b0;
   logic        enc_b = 1'b0;
   logic        btn_n = 1'b1;
   logic [1:0]  sel_idx;
   logic        edit_mode;
   logic [7:0]  sel_val;
   logic [31:0] params;
   logic        update_pulse;
   logic        long_press;

   int checks = 0;
   int errors = 0;
   int upd_cnt = 0;
   int long_cnt = 0;
   int upd_base;
   int long_base;
   int long_at;

   always #5 clk = ~clk;

   encoder_menu_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enc_a        (enc_a),
      .enc_b        (enc_b),
      .btn_n        (btn_n),
      .sel_idx      (sel_idx),
      .edit_mode    (edit_mode),
      .sel_val      (sel_val),
      .params       (params),
      .update_pulse (update_pulse),
      .long_press   (long_press)
   );

   always @(posedge clk) begin
      if (update_pulse === 1'b1) upd_cnt <= upd_cnt + 1;
      if (long_press === 1'b1) long_cnt <= long_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [1:0] ba);
      @(negedge clk);
      {enc_b, enc_a} = ba;
      repeat (3) @(negedge clk);
   endtask

   task automatic cw();
      step(2'b01); step(2'b11); step(2'b10); step(2'b00);
      repeat (8) @(negedge clk);
   endtask

   task automatic ccw();
      step(2'b10); step(2'b11); step(2'b01); step(2'b00);
      repeat (8) @(negedge clk);
   endtask

   task automatic press(input int cycles);
      @(negedge clk);
      btn_n = 1'b0;
      repeat (cycles) @(negedge clk);
      btn_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      repeat (10) @(negedge clk);
      chk("rst_sel_idx", 32'(sel_idx), 32'd0);
      chk("rst_edit_mode", 32'(edit_mode), 32'd0);
      chk("rst_sel_val", 32'(sel_val), 32'd0);
      chk("rst_params", params, 32'd0);
      chk("rst_update", 32'(update_pulse), 32'd0);
      chk("rst_long", 32'(long_press), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // NAV selection with wrap
      cw();  chk("nav_cw1", 32'(sel_idx), 32'd1);
      cw();  chk("nav_cw2", 32'(sel_idx), 32'd2);
      ccw(); chk("nav_ccw1", 32'(sel_idx), 32'd1);
      ccw(); chk("nav_ccw2", 32'(sel_idx), 32'd0);
      ccw(); chk("nav_ccw_wrap", 32'(sel_idx), 32'd3);
      cw();  chk("nav_cw_wrap", 32'(sel_idx), 32'd0);
      chk("nav_no_update", 32'(upd_cnt), 32'd0);

      // Short press enters EDIT
      press(50);
      chk("short_edit", 32'(edit_mode), 32'd1);
      chk("short_no_long", 32'(long_cnt), 32'd0);

      // Saturation at 0, then increments
      upd_base = upd_cnt;
      repeat (4) ccw();
      chk("sat0_val", 32'(sel_val), 32'd0);
      chk("sat0_no_update", 32'(upd_cnt - upd_base), 32'd0);
      repeat (3) cw();
      chk("inc_val", 32'(sel_val), 32'd3);
      chk("inc_param0", params, 32'h0000_0003);
      chk("inc_updates", 32'(upd_cnt - upd_base), 32'd3);
      chk("inc_sel_idx", 32'(sel_idx), 32'd0);

      // Long press: strobe 64 cycles after the debounced press (6 edges after raw press)
      upd_base  = upd_cnt;
      long_base = long_cnt;
      long_at   = -1;
      @(negedge clk);
      btn_n = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (long_press === 1'b1 && long_at < 0) long_at = i;
      end
      chk("long_timing", 32'(long_at), 32'd70);
      @(negedge clk);
      btn_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("long_strobes", 32'(long_cnt - long_base), 32'd1);
      chk("long_val", 32'(sel_val), 32'd0);
      chk("long_update", 32'(upd_cnt - upd_base), 32'd1);
      chk("long_nav", 32'(edit_mode), 32'd0);

      // 3-cycle button glitch
      long_base = long_cnt;
      press(3);
      chk("glitch_btn_mode", 32'(edit_mode), 32'd0);
      chk("glitch_btn_long", 32'(long_cnt - long_base), 32'd0);

      // Invalid jump and reversal produce no detent
      step(2'b11); step(2'b10); step(2'b00);
      repeat (8) @(negedge clk);
      chk("jump_no_detent", 32'(sel_idx), 32'd0);
      step(2'b01); step(2'b00);
      repeat (8) @(negedge clk);
      chk("revert_no_detent", 32'(sel_idx), 32'd0);

      // Reset in the middle of a detent
      cw();
      chk("pre_reset_sel", 32'(sel_idx), 32'd1);
      step(2'b01); step(2'b11);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_sel", 32'(sel_idx), 32'd0);
      chk("midrst_params", params, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      step(2'b10); step(2'b00);
      repeat (8) @(negedge clk);
      chk("post_rst_no_step", 32'(sel_idx), 32'd0);
      chk("post_rst_mode", 32'(edit_mode), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
